// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: entry layout, FSM states and helpers.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {instr, pc} entries; flush wins over push/pop,
// and a pop in the same cycle frees the slot for a push even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; an empty queue presents zeros instead.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = (count != '0) ? mem[rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, imem req/gnt/rvalid, in-order queue to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_nx;
    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic          fault;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)         fault <= 1'b0;
        else if (redirect) fault <= |redirect_pc[1:0];
    end
    assign fetch_misaligned = fault;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign fault = 1'b0;
`endif

    assign occupancy = {1'b0, inflight} + {1'b0, count};

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        case (state)
            IDLE: state_nx = RUN;
            RUN: begin
                state_nx = RUN;
                imem_req = ~redirect & ~fault & (occupancy < CAP);
            end
        endcase
    end

    assign imem_addr = pc;
    assign issue     = imem_req & imem_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_nx;
            inflight <= inflight + CW'(issue) - CW'(imem_rvalid);
            if (redirect) begin
                pc      <= word_align(redirect_pc);
                discard <= inflight - CW'(imem_rvalid);
            end else begin
                if (issue) pc <= pc + 32'd4;
                if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
            end
        end
    end

    // Responses return in order and every live one was issued from the current
    // PC stream, so the oldest live request sits inflight words behind pc.
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = pc - 32'({inflight, 2'b00});
    assign push             = imem_rvalid & ~redirect & (discard == '0);

    assign instr_valid = (count != '0) & ~redirect & ~fault;
    assign pop         = instr_valid & instr_ready;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(redirect),
        .wdata(push_entry),
        .rdata(head),
        .count(count)
    );

    assign instr         = head.instr;
    assign instr_pc      = head.pc;
    assign instr_pcplus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model plus a
// randomised-latency in-order instruction memory.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_pcplus4(instr_pcplus4),
        .instr_ready  (instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; bit stale; } oreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } qent_t;

    mreq_t mq[$];      // memory: granted requests awaiting their response slot
    oreq_t m_out[$];   // model: outstanding requests, oldest first
    qent_t m_q[$];     // model: instructions waiting for decode

    logic [31:0] m_pc;
    bit          m_run;
    bit          m_fault;
    int cyc, last_due, lat_min, lat_max, gnt_pct;
    int n_gnt, n_pop, n_cmp, n_bad;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete(); m_out.delete(); m_q.delete();
        m_pc = RPC; m_run = 0; m_fault = 0; last_due = cyc;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model
    // to what the coming edge should produce.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
        logic        rv;
        logic [31:0] rd;
        logic        g;
        logic        exp_req;
        logic        exp_v;
        oreq_t       o;
        int          d;
        @(negedge clk);
        cyc++;
        rv = 1'b0; rd = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1; rd = memword(mq[0].addr); void'(mq.pop_front());
        end
        g = ($urandom_range(99) < gnt_pct);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        redirect = redir; redirect_pc = rpc; instr_ready = rdy;
        #1;
        exp_req = m_run && !redir && !m_fault && ((m_out.size() + m_q.size()) < DEPTH);
        n_cmp++;
        if (imem_req !== exp_req) begin
            n_bad++; $display("FAIL imem_req cyc=%0d got %b want %b", cyc, imem_req, exp_req);
        end
        n_cmp++;
        if (imem_addr !== m_pc) begin
            n_bad++; $display("FAIL imem_addr cyc=%0d got %h want %h", cyc, imem_addr, m_pc);
        end
        exp_v = (m_q.size() != 0) && !redir && !m_fault;
        n_cmp++;
        if (instr_valid !== exp_v) begin
            n_bad++; $display("FAIL instr_valid cyc=%0d got %b want %b", cyc, instr_valid, exp_v);
        end
        if (exp_v) begin
            n_cmp++;
            if (instr !== m_q[0].instr || instr_pc !== m_q[0].pc || instr_pcplus4 !== m_q[0].pc + 32'd4) begin
                n_bad++;
                $display("FAIL head cyc=%0d got %h/%h/%h want %h/%h/%h", cyc, instr, instr_pc,
                         instr_pcplus4, m_q[0].instr, m_q[0].pc, m_q[0].pc + 32'd4);
            end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++;
        if (fetch_misaligned !== m_fault) begin
            n_bad++; $display("FAIL fetch_misaligned cyc=%0d got %b want %b", cyc, fetch_misaligned, m_fault);
        end
`endif
        if (exp_v && rdy) begin
            void'(m_q.pop_front()); n_pop++;
        end
        if (rv && m_out.size() > 0) begin
            o = m_out.pop_front();
            if (!o.stale && !redir) m_q.push_back('{instr: memword(o.addr), pc: o.addr});
        end
        if (imem_req && g) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: imem_addr, due: d});
        end
        if (exp_req && g) begin
            m_out.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4; n_gnt++;
        end
        if (redir) begin
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            m_fault = (rpc[1:0] != 2'b00);
`endif
        end
        m_run = 1;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        do_reset();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== RPC) begin n_bad++; $display("FAIL rst_addr got %h want %h", imem_addr, RPC); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", instr_pc); end
        n_cmp++; if (instr_pcplus4 !== 32'h4) begin n_bad++; $display("FAIL rst_pcplus4 got %h want 4", instr_pcplus4); end
    endtask

    task automatic test_stream();
        int p0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        p0 = n_pop;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        n_cmp++;
        if (n_pop - p0 != 10) begin
            n_bad++; $display("FAIL stream_rate got %0d want 10", n_pop - p0);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        do_reset();
        g0 = n_gnt;
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b0);
        n_cmp++;
        if (n_gnt - g0 != DEPTH) begin
            n_bad++; $display("FAIL bp_grants got %0d want %0d", n_gnt - g0, DEPTH);
        end
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL bp_req_held got %b want 0", imem_req);
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic wait_first_valid(input logic [31:0] want_pc, input string nm);
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, '0, 1'b1);
            if (instr_valid === 1'b1) found = 1;
        end
        n_cmp++;
        if (!found || instr_pc !== want_pc || instr !== memword(want_pc)) begin
            n_bad++;
            $display("FAIL %s found=%0d got %h/%h want %h/%h", nm, found, instr_pc, instr, want_pc, memword(want_pc));
        end
    endtask

    task automatic test_redirect_stale();
        lat_min = 3; lat_max = 3; gnt_pct = 100;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        wait_first_valid(32'h0000_0200, "redir_stale_first");
    endtask

    task automatic test_redirect_rvalid();
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0040, 1'b1);
        wait_first_valid(32'h0000_0040, "redir_rvalid_first");
    endtask

    task automatic test_reset_mid();
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        do_reset();
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RPC) begin
            n_bad++;
            $display("FAIL midrst got req=%b v=%b addr=%h want 0/0/%h", imem_req, instr_valid, imem_addr, RPC);
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_misalign();
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0102, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        n_cmp++;
        if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0) begin
            n_bad++; $display("FAIL mis_trap got flag=%b req=%b want 1/0", fetch_misaligned, imem_req);
        end
        step(1'b1, 32'h0000_0104, 1'b1);
        step(1'b0, '0, 1'b1);
        n_cmp++;
        if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0104) begin
            n_bad++;
            $display("FAIL mis_clear got flag=%b req=%b addr=%h want 0/1/00000104", fetch_misaligned, imem_req, imem_addr);
        end
`else
        step(1'b0, '0, 1'b1);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
            n_bad++; $display("FAIL mis_force got req=%b addr=%h want 1/00000100", imem_req, imem_addr);
        end
`endif
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic        rd;
        logic [31:0] rpc;
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            rd  = ($urandom_range(99) < 4);
            rpc = $urandom & 32'h0000_3FFC;
            if ($urandom_range(9) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
            step(rd, rpc, ($urandom_range(99) < 60));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_gnt = 0; n_pop = 0; n_cmp = 0; n_bad = 0;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        test_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_rvalid();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
